dbg_snapshot_ctrl: RTL

Sequencer that takes a consistent snapshot of the CPU register file for the VGA debug screen once per frame. On each vertical-sync assertion it reads every register through the register file's debug read port into a back buffer, then swaps buffers. The debug screen always reads a stable front buffer and never sees a half-updated frame. It sits between the CPU debug read port and the screen's `regAddr`/`regData` lookup.

---
 rtl/dbg_snapshot_ctrl.sv | 156 +++++++++++++++
 1 files changed

// File: rtl/dbg_snapshot_ctrl.sv
// Once-per-frame snapshot of the CPU register file into a double buffer for the
// debug screen; the screen always reads the stable front bank.
module dbg_snapshot_ctrl #(
    parameter int   NREGS     = 32,
    parameter int   AW        = 5,
    parameter int   DW        = 32,
    parameter int   RD_LAT    = 1,
    parameter logic VS_ACTIVE = 1'b0
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          vsync,
    input  logic          freeze,
    output logic          rf_req,
    output logic [AW-1:0] rf_addr,
    input  logic          rf_gnt,
    input  logic [DW-1:0] rf_data,
    input  logic [AW-1:0] scr_addr,
    output logic [DW-1:0] scr_data,
    output logic          busy,
    output logic [7:0]    frame_cnt,
    output logic          overrun
);

    // state | meaning
    // IDLE  | waiting for a vsync start event
    // ISSUE | issuing one read request per register
    // DRAIN | all requests accepted, waiting for outstanding read data
    // SWAP  | one cycle: flip front bank, count the frame
    typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_DRAIN, S_SWAP} state_t;

    localparam int            IW      = (NREGS > 1) ? $clog2(NREGS) : 1;
    localparam logic [AW-1:0] LAST    = AW'(NREGS - 1);
    localparam logic [AW:0]   NREGS_W = (AW+1)'(NREGS);

    state_t          state_q;
    logic            vs_q;
    logic            front_q;
    logic            rf_req_q;
    logic            busy_q;
    logic            overrun_q;
    logic [AW-1:0]   issue_ptr_q;
    logic [7:0]      frame_cnt_q;
    logic [DW-1:0]   bank_q [2][NREGS];

    logic            start_ev;
    logic            accept;
    logic            cap_v;
    logic [AW-1:0]   cap_addr;
    logic            pipe_empty;

    assign start_ev = (vsync == VS_ACTIVE) && (vs_q != VS_ACTIVE);
    assign accept   = rf_req_q && rf_gnt;

    generate
        if (RD_LAT == 0) begin : g_nopipe
            assign cap_v      = accept;
            assign cap_addr   = issue_ptr_q;
            assign pipe_empty = 1'b1;
        end else begin : g_pipe
            logic [RD_LAT-1:0] tv_q;
            logic [AW-1:0]     ta_q [RD_LAT];

            always_ff @(posedge clk or posedge reset) begin
                if (reset) begin
                    tv_q <= '0;
                    for (int i = 0; i < RD_LAT; i++) ta_q[i] <= '0;
                end else begin
                    tv_q[0] <= accept;
                    ta_q[0] <= issue_ptr_q;
                    for (int i = 1; i < RD_LAT; i++) begin
                        tv_q[i] <= tv_q[i-1];
                        ta_q[i] <= ta_q[i-1];
                    end
                end
            end

            assign cap_v      = tv_q[RD_LAT-1];
            assign cap_addr   = ta_q[RD_LAT-1];
            assign pipe_empty = ~|tv_q;
        end
    endgenerate

    // Captures always land in the back bank; SWAP only happens once the pipe is empty.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int b = 0; b < 2; b++)
                for (int i = 0; i < NREGS; i++)
                    bank_q[b][i] <= '0;
        end else if (cap_v) begin
            bank_q[~front_q][cap_addr[IW-1:0]] <= rf_data;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= S_IDLE;
            vs_q        <= ~VS_ACTIVE;
            front_q     <= 1'b0;
            rf_req_q    <= 1'b0;
            busy_q      <= 1'b0;
            overrun_q   <= 1'b0;
            issue_ptr_q <= '0;
            frame_cnt_q <= '0;
        end else begin
            vs_q <= vsync;
            if (start_ev && state_q != S_IDLE)
                overrun_q <= 1'b1;
            case (state_q)
                S_IDLE: begin
                    if (start_ev && !freeze) begin
                        state_q     <= S_ISSUE;
                        issue_ptr_q <= '0;
                        rf_req_q    <= 1'b1;
                        busy_q      <= 1'b1;
                    end
                end
                S_ISSUE: begin
                    if (rf_gnt) begin
                        if (issue_ptr_q == LAST) begin
                            state_q     <= S_DRAIN;
                            rf_req_q    <= 1'b0;
                            issue_ptr_q <= '0;
                        end else begin
                            issue_ptr_q <= issue_ptr_q + 1'b1;
                        end
                    end
                end
                S_DRAIN: begin
                    if (pipe_empty)
                        state_q <= S_SWAP;
                end
                S_SWAP: begin
                    front_q     <= ~front_q;
                    frame_cnt_q <= frame_cnt_q + 8'd1;
                    busy_q      <= 1'b0;
                    state_q     <= S_IDLE;
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    always_comb begin
        scr_data = '0;
        if ({1'b0, scr_addr} < NREGS_W)
            scr_data = bank_q[front_q][scr_addr[IW-1:0]];
    end

    assign rf_req    = rf_req_q;
    assign rf_addr   = issue_ptr_q;
    assign busy      = busy_q;
    assign frame_cnt = frame_cnt_q;
    assign overrun   = overrun_q;

endmodule
